// File: rtl/signed_sat_pkg.sv
// Shared types and width-dependent limit helpers for the saturating
// accumulator slice.
package signed_sat_pkg;

    typedef enum logic [1:0] {
        OVF_NONE = 2'd0,
        OVF_POS  = 2'd1,
        OVF_NEG  = 2'd2
    } ovf_kind_t;

    // Limits are returned as 64-bit patterns; callers cast down to their width.
    function automatic logic [63:0] max_pos(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_neg(input int unsigned width);
        return ~64'd0 << (width - 1);
    endfunction

    function automatic ovf_kind_t classify_ovf(input logic pos, input logic neg);
        ovf_kind_t kind;
        kind = OVF_NONE;
        if (pos) begin
            kind = OVF_POS;
        end else if (neg) begin
            kind = OVF_NEG;
        end
        return kind;
    endfunction

endpackage

// File: rtl/sat_add_w.sv
// Combinational signed adder of two W_A-bit operands with optional clamping
// to the representable range and overflow direction flags.
module sat_add_w
    import signed_sat_pkg::*;
#(
    parameter int unsigned W_A    = 12,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic [W_A-1:0] a,
    input  logic [W_A-1:0] b,
    output logic [W_A-1:0] sum,
    output logic           ovf_pos,
    output logic           ovf_neg
);

    localparam logic [W_A-1:0] MAX_POS = W_A'(max_pos(W_A));
    localparam logic [W_A-1:0] MIN_NEG = W_A'(min_neg(W_A));

    logic [W_A:0] w_full;

    // With one guard bit, overflow shows as a disagreement between the true
    // sign (bit W_A) and the sign of the truncated result (bit W_A-1).
    always_comb begin
        w_full  = {a[W_A-1], a} + {b[W_A-1], b};
        ovf_pos = !w_full[W_A] && w_full[W_A-1];
        ovf_neg = w_full[W_A] && !w_full[W_A-1];
        sum     = w_full[W_A-1:0];
        if (SAT_EN) begin
            if (ovf_pos) begin
                sum = MAX_POS;
            end else if (ovf_neg) begin
                sum = MIN_NEG;
            end
        end
    end

endmodule

// File: rtl/signed_sat_accumulator.sv
// Streaming per-frame signed accumulator with clamping, sticky overflow flag
// and beat counter; valid/ready on both input and output sides.
module signed_sat_accumulator
    import signed_sat_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned ACC_W  = 12,
    parameter int unsigned CNT_W  = 8,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    input  logic             in_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_count
);

    logic [ACC_W-1:0] r_acc;
    logic             r_sat_sticky;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_data;
    logic             r_out_sat;
    logic [CNT_W-1:0] r_out_count;

    logic             w_in_ready;
    logic             w_accept;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_operand;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf_pos;
    logic             w_ovf_neg;
    ovf_kind_t        w_ovf_kind;
    logic             w_beat_sat;
    logic             w_sticky_next;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;

    // A clear coinciding with a beat makes that beat the first of a new frame.
    always_comb begin
        w_base        = in_clear ? '0 : r_acc;
        w_operand     = ACC_W'($signed(in_data));
        w_cnt_base    = in_clear ? '0 : r_cnt;
        w_cnt_next    = (w_cnt_base == '1) ? '1 : w_cnt_base + 1'b1;
        w_ovf_kind    = classify_ovf(w_ovf_pos, w_ovf_neg);
        w_beat_sat    = (w_ovf_kind != OVF_NONE);
        w_sticky_next = (in_clear ? 1'b0 : r_sat_sticky) | w_beat_sat;
    end

    sat_add_w #(
        .W_A    (ACC_W),
        .SAT_EN (SAT_EN)
    ) u_step_add (
        .a       (w_base),
        .b       (w_operand),
        .sum     (w_sum),
        .ovf_pos (w_ovf_pos),
        .ovf_neg (w_ovf_neg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc        <= '0;
            r_sat_sticky <= 1'b0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sat    <= 1'b0;
            r_out_count  <= '0;
        end else if (w_accept) begin
            if (in_last) begin
                r_acc        <= '0;
                r_sat_sticky <= 1'b0;
                r_cnt        <= '0;
                r_out_valid  <= 1'b1;
                r_out_data   <= w_sum;
                r_out_sat    <= w_sticky_next;
                r_out_count  <= w_cnt_next;
            end else begin
                r_acc        <= w_sum;
                r_sat_sticky <= w_sticky_next;
                r_cnt        <= w_cnt_next;
                if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end else begin
            // Clear without a beat only wipes the partial frame; a pending
            // result stays until the consumer takes it.
            if (in_clear) begin
                r_acc        <= '0;
                r_sat_sticky <= 1'b0;
                r_cnt        <= '0;
            end
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Bench for signed_sat_accumulator: three configurations share one stimulus
// stream and are compared every cycle against an integer-arithmetic model.
module tb_signed_sat_accumulator;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = '0;
    logic       in_last   = 1'b0;
    logic       in_clear  = 1'b0;
    logic       out_ready = 1'b0;

    logic        a_in_ready, b_in_ready, c_in_ready;
    logic        a_out_valid, b_out_valid, c_out_valid;
    logic [11:0] a_out_data;
    logic [7:0]  b_out_data, c_out_data;
    logic        a_out_sat, b_out_sat, c_out_sat;
    logic [7:0]  a_out_count, b_out_count, c_out_count;

    signed_sat_accumulator #(.W(8), .ACC_W(12), .CNT_W(8), .SAT_EN(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .in_clear(in_clear),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_sat(a_out_sat), .out_count(a_out_count)
    );

    signed_sat_accumulator #(.W(8), .ACC_W(8), .CNT_W(8), .SAT_EN(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .in_clear(in_clear),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_sat(b_out_sat), .out_count(b_out_count)
    );

    signed_sat_accumulator #(.W(8), .ACC_W(8), .CNT_W(8), .SAT_EN(1'b0)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_last(in_last), .in_clear(in_clear),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .out_sat(c_out_sat), .out_count(c_out_count)
    );

    // DUT outputs widened to 32-bit signed so X/Z stay visible in compares.
    logic signed [31:0] d_rdy[NI], d_ov[NI], d_data[NI], d_sat[NI], d_cnt[NI];
    always_comb begin
        d_rdy[0]  = {31'd0, a_in_ready};
        d_rdy[1]  = {31'd0, b_in_ready};
        d_rdy[2]  = {31'd0, c_in_ready};
        d_ov[0]   = {31'd0, a_out_valid};
        d_ov[1]   = {31'd0, b_out_valid};
        d_ov[2]   = {31'd0, c_out_valid};
        d_data[0] = 32'($signed(a_out_data));
        d_data[1] = 32'($signed(b_out_data));
        d_data[2] = 32'($signed(c_out_data));
        d_sat[0]  = {31'd0, a_out_sat};
        d_sat[1]  = {31'd0, b_out_sat};
        d_sat[2]  = {31'd0, c_out_sat};
        d_cnt[0]  = {24'd0, a_out_count};
        d_cnt[1]  = {24'd0, b_out_count};
        d_cnt[2]  = {24'd0, c_out_count};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame sums in plain integers, clamped or wrapped to the range.
    int accw[NI]  = '{12, 8, 8};
    int saten[NI] = '{1, 1, 0};
    int m_acc[NI], m_sat[NI], m_cnt[NI], m_ov[NI], m_od[NI], m_os[NI], m_oc[NI];
    bit started = 1'b0;

    initial begin
        for (int k = 0; k < NI; k++) begin
            m_acc[k] = 0; m_sat[k] = 0; m_cnt[k] = 0;
            m_ov[k] = 0; m_od[k] = 0; m_os[k] = 0; m_oc[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            int span, maxv, minv, s, sticky, cnt;
            bit flag, rdy;
            span = 1 << accw[k];
            maxv = span / 2 - 1;
            minv = -(span / 2);
            if (!rst) begin
                m_acc[k] = 0; m_sat[k] = 0; m_cnt[k] = 0;
                m_ov[k] = 0; m_od[k] = 0; m_os[k] = 0; m_oc[k] = 0;
            end else begin
                rdy = (m_ov[k] == 0) || out_ready;
                if (in_valid && rdy) begin
                    s = (in_clear ? 0 : m_acc[k]) + int'($signed(in_data));
                    flag = (s > maxv) || (s < minv);
                    if (flag) begin
                        if (saten[k] != 0) begin
                            s = (s > maxv) ? maxv : minv;
                        end else begin
                            s = (s - minv) % span;
                            if (s < 0) s += span;
                            s += minv;
                        end
                    end
                    sticky = (in_clear ? 0 : m_sat[k]) | int'(flag);
                    cnt = (in_clear ? 0 : m_cnt[k]) + 1;
                    if (cnt > 255) cnt = 255;
                    if (in_last) begin
                        m_od[k] = s; m_os[k] = sticky; m_oc[k] = cnt; m_ov[k] = 1;
                        m_acc[k] = 0; m_sat[k] = 0; m_cnt[k] = 0;
                    end else begin
                        m_acc[k] = s; m_sat[k] = sticky; m_cnt[k] = cnt;
                        if (out_ready) m_ov[k] = 0;
                    end
                end else begin
                    if (in_clear) begin
                        m_acc[k] = 0; m_sat[k] = 0; m_cnt[k] = 0;
                    end
                    if (out_ready) m_ov[k] = 0;
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("inst%0d in_ready", k), d_rdy[k], (m_ov[k] == 0 || out_ready) ? 1 : 0);
                check($sformatf("inst%0d out_valid", k), d_ov[k], m_ov[k]);
                check($sformatf("inst%0d out_data", k), d_data[k], m_od[k]);
                check($sformatf("inst%0d out_sat", k), d_sat[k], m_os[k]);
                check($sformatf("inst%0d out_count", k), d_cnt[k], m_oc[k]);
            end
        end
    end

    task automatic drive(input bit v, input logic signed [7:0] d, input bit l, input bit c);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        in_clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input int k, input int data, input int sat, input int cnt);
        check({tag, " valid"}, d_ov[k], 1);
        check({tag, " data"}, d_data[k], data);
        check({tag, " sat"}, d_sat[k], sat);
        check({tag, " count"}, d_cnt[k], cnt);
    endtask

    initial begin
        logic signed [31:0] held;

        // Reset
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            check("reset out_valid", d_ov[k], 0);
            check("reset out_data", d_data[k], 0);
            check("reset out_count", d_cnt[k], 0);
            check("reset in_ready", d_rdy[k], 1);
        end

        out_ready = 1'b1;
        drive(1, 8'sd100, 0, 0);
        drive(1, -8'sd30, 0, 0);
        drive(1, 8'sd5, 1, 0);
        check_result("f1 A", 0, 75, 0, 3);
        check_result("f1 B", 1, 75, 0, 3);
        drive(0, 0, 0, 0);
        check("f1 drained", d_ov[0], 0);

        drive(1, 8'sd120, 0, 0);
        drive(1, 8'sd20, 0, 0);
        drive(1, -8'sd10, 1, 0);
        check_result("f2 A", 0, 130, 0, 3);
        check_result("f2 B", 1, 117, 1, 3);
        check_result("f2 C", 2, -126, 1, 3);

        // Back-to-back: last beat lands while previous result is consumed
        drive(1, -8'sd100, 0, 0);
        drive(1, -8'sd100, 1, 0);
        check_result("f3 A", 0, -200, 0, 2);
        check_result("f3 B", 1, -128, 1, 2);
        check_result("f3 C", 2, 56, 1, 2);

        // Back-pressure holds the result and blocks input
        out_ready = 1'b0;
        held = d_data[0];
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'sd50, 1, 0);
            check("bp in_ready", d_rdy[0], 0);
            check("bp data hold", d_data[0], int'(held));
            check("bp valid hold", d_ov[0], 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", d_rdy[0], 1);
        drive(1, 8'sd50, 1, 0);
        check_result("bp beat A", 0, 50, 0, 1);

        drive(1, 8'sd10, 0, 0);
        drive(1, 8'sd20, 0, 0);
        drive(0, 0, 0, 1);
        drive(1, 8'sd7, 1, 0);
        check_result("clr alone A", 0, 7, 0, 1);
        drive(1, 8'sd9, 0, 0);
        drive(1, 8'sd3, 1, 1);
        check_result("clr beat A", 0, 3, 0, 1);
        drive(1, 8'sd120, 0, 0);
        drive(1, 8'sd20, 0, 0);
        drive(1, 8'sd5, 1, 1);
        check_result("clr sticky B", 1, 5, 0, 1);

        // Long frame: counter and 12-bit accumulator both saturate
        for (int i = 0; i < 300; i++) drive(1, 8'sd127, 0, 0);
        drive(1, -8'sd1, 1, 0);
        check_result("long A", 0, 2046, 1, 255);
        check_result("long B", 1, 126, 1, 255);
        check_result("long C", 2, -45, 1, 255);

        drive(1, 8'sd10, 0, 0);
        drive(1, 8'sd20, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0);
        rst = 1'b1;
        check("rst mid out_valid", d_ov[0], 0);
        check("rst mid out_data", d_data[0], 0);
        check("rst mid in_ready", d_rdy[0], 1);
        drive(1, 8'sd5, 1, 0);
        check_result("post rst A", 0, 5, 0, 1);
        out_ready = 1'b0;
        drive(1, 8'sd6, 1, 0);
        drive(0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0);
        rst = 1'b1;
        check("rst pend out_valid", d_ov[0], 0);
        check("rst pend out_count", d_cnt[0], 0);
        check("rst pend in_ready", d_rdy[0], 1);
        out_ready = 1'b1;
        drive(1, 8'sd4, 1, 0);
        check_result("post rst2 A", 0, 4, 0, 1);

        for (int i = 0; i < 4000; i++) begin
            int sel;
            rst       = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            sel       = int'($urandom_range(0, 3));
            in_data   = (sel == 0) ? 8'sd127 : (sel == 1) ? -8'sd128 : 8'($urandom);
            in_last   = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            in_clear  = ($urandom_range(0, 31) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end

        rst = 1'b1;
        drive(0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
